// File: rtl/i2c_globals_pkg.sv
// Shared I2C definitions: bus-level constants, transfer direction and the
// byte-engine target state encoding.
package i2c_globals_pkg;

  localparam int DATA_LENGTH            = 8;
  localparam int REGISTER_ADDRESS_WIDTH = 8;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  typedef enum logic {
    WRITE = 1'b0,
    READ  = 1'b1
  } read_write_e;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    REG,
    REG_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    WAIT_STOP
  } i2c_target_state_e;

endpackage

// File: rtl/i2c_sync_edge_detect.sv
// SCL/SDA synchronizers plus one history flop; flags SCL edges and
// START/STOP conditions on the synchronized signals.
module i2c_sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic pclk,
  input  logic areset,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_d;
  logic                   r_sda_d;
  logic                   w_scl;
  logic                   w_sda;

  // Preset to the idle bus level so reset release never looks like START.
  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
    end
  end

  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign o_sda      = w_sda;
  assign o_scl_rise =  w_scl & ~r_scl_d;
  assign o_scl_fall = ~w_scl &  r_scl_d;
  assign o_start    =  w_scl & r_scl_d &  r_sda_d & ~w_sda;
  assign o_stop     =  w_scl & r_scl_d & ~r_sda_d &  w_sda;

endmodule

// File: rtl/i2c_target_byte_engine.sv
// I2C target front end: address/pointer decode, byte writes to and byte reads
// from a register-file port, open-drain ACK and read-data drive.
module i2c_target_byte_engine #(
  parameter int         DATA_LENGTH            = i2c_globals_pkg::DATA_LENGTH,
  parameter int         REGISTER_ADDRESS_WIDTH = i2c_globals_pkg::REGISTER_ADDRESS_WIDTH,
  parameter logic [6:0] TARGET_ADDRESS         = 7'h68,
  parameter int         SYNC_STAGES            = 2
) (
  input  logic                              pclk,
  input  logic                              areset,
  input  logic                              scl_i,
  input  logic                              sda_i,
  output logic                              sda_oe,
  output logic [REGISTER_ADDRESS_WIDTH-1:0] reg_addr,
  output logic                              reg_wr_en,
  output logic [DATA_LENGTH-1:0]            reg_wdata,
  output logic                              reg_rd_en,
  input  logic [DATA_LENGTH-1:0]            reg_rdata,
  output logic                              busy,
  output logic                              nack_seen
);
  import i2c_globals_pkg::*;

  localparam int CW = $clog2(DATA_LENGTH);

  i2c_target_state_e                 r_state;
  logic [CW-1:0]                     r_bitcnt;
  logic [DATA_LENGTH-1:0]            r_shreg;
  logic [REGISTER_ADDRESS_WIDTH-1:0] r_ptr;
  logic                              r_ack_ph;
  read_write_e                       r_rw;
  logic                              r_sda_oe;
  logic                              r_wr_en;
  logic [DATA_LENGTH-1:0]            r_wdata;
  logic                              r_rd_en;
  logic                              r_busy;
  logic                              r_nack;

  logic                   w_sda;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_start;
  logic                   w_stop;
  logic                   w_last;
  logic [DATA_LENGTH-1:0] w_byte;

  i2c_sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .pclk       (pclk),
    .areset     (areset),
    .i_scl      (scl_i),
    .i_sda      (sda_i),
    .o_sda      (w_sda),
    .o_scl_rise (w_rise),
    .o_scl_fall (w_fall),
    .o_start    (w_start),
    .o_stop     (w_stop)
  );

  assign w_byte = {r_shreg[DATA_LENGTH-2:0], w_sda};
  assign w_last = (r_bitcnt == CW'(DATA_LENGTH - 1));

  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      r_state  <= IDLE;
      r_bitcnt <= '0;
      r_shreg  <= '0;
      r_ptr    <= '0;
      r_ack_ph <= 1'b0;
      r_rw     <= WRITE;
      r_sda_oe <= 1'b0;
      r_wr_en  <= 1'b0;
      r_wdata  <= '0;
      r_rd_en  <= 1'b0;
      r_busy   <= 1'b0;
      r_nack   <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      r_rd_en <= 1'b0;
      r_nack  <= 1'b0;
      // Post-increment lands the cycle after the write strobe at the old pointer.
      if (r_wr_en) r_ptr <= r_ptr + 1'b1;

      if (w_start) begin
        r_state  <= ADDR;
        r_bitcnt <= '0;
        r_sda_oe <= 1'b0;
      end else if (w_stop) begin
        r_state  <= IDLE;
        r_bitcnt <= '0;
        r_busy   <= 1'b0;
        r_sda_oe <= 1'b0;
      end else begin
        case (r_state)
          ADDR, REG, WR_DATA: begin
            if (w_rise) begin
              r_shreg  <= w_byte;
              r_bitcnt <= r_bitcnt + 1'b1;
              if (w_last) begin
                r_bitcnt <= '0;
                r_ack_ph <= 1'b0;
                if (r_state == ADDR) begin
                  if (w_byte[DATA_LENGTH-1 -: 7] == TARGET_ADDRESS) begin
                    r_state <= ADDR_ACK;
                    r_busy  <= 1'b1;
                    r_rw    <= read_write_e'(w_byte[0]);
                  end else begin
                    r_state <= WAIT_STOP;
                  end
                end else if (r_state == REG) begin
                  r_ptr   <= REGISTER_ADDRESS_WIDTH'(w_byte);
                  r_state <= REG_ACK;
                end else begin
                  r_wdata <= w_byte;
                  r_wr_en <= 1'b1;
                  r_state <= WR_ACK;
                end
              end
            end
          end
          // First fall drives ACK, second fall releases and moves on.
          ADDR_ACK, REG_ACK, WR_ACK: begin
            if (w_fall) begin
              if (!r_ack_ph) begin
                r_sda_oe <= ~ACK;
                r_ack_ph <= 1'b1;
              end else begin
                r_ack_ph <= 1'b0;
                r_bitcnt <= '0;
                if (r_state == ADDR_ACK && r_rw == READ) begin
                  r_state  <= RD_DATA;
                  r_rd_en  <= 1'b1;
                  r_shreg  <= reg_rdata;
                  r_sda_oe <= ~reg_rdata[DATA_LENGTH-1];
                end else begin
                  r_sda_oe <= 1'b0;
                  r_state  <= (r_state == ADDR_ACK) ? REG : WR_DATA;
                end
              end
            end
          end
          RD_DATA: begin
            if (w_fall) begin
              if (w_last) begin
                r_sda_oe <= 1'b0;
                r_bitcnt <= '0;
                r_ack_ph <= 1'b0;
                r_state  <= RD_ACK;
              end else begin
                r_shreg  <= {r_shreg[DATA_LENGTH-2:0], 1'b0};
                r_sda_oe <= ~r_shreg[DATA_LENGTH-2];
                r_bitcnt <= r_bitcnt + 1'b1;
              end
            end
          end
          RD_ACK: begin
            if (w_rise) begin
              if (w_sda == NACK) begin
                r_nack  <= 1'b1;
                r_state <= WAIT_STOP;
              end else begin
                r_ptr    <= r_ptr + 1'b1;
                r_ack_ph <= 1'b1;
              end
            end else if (w_fall && r_ack_ph) begin
              r_ack_ph <= 1'b0;
              r_bitcnt <= '0;
              r_state  <= RD_DATA;
              r_rd_en  <= 1'b1;
              r_shreg  <= reg_rdata;
              r_sda_oe <= ~reg_rdata[DATA_LENGTH-1];
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sda_oe    = r_sda_oe;
  assign reg_addr  = r_ptr;
  assign reg_wr_en = r_wr_en;
  assign reg_wdata = r_wdata;
  assign reg_rd_en = r_rd_en;
  assign busy      = r_busy;
  assign nack_seen = r_nack;

endmodule

// File: tb/tb_i2c_target_byte_engine.sv
// Bench for i2c_target_byte_engine: bus-level master tasks, a transaction
// model of expected register accesses, and a per-cycle strobe checker.
module tb_i2c_target_byte_engine;

  localparam int Q = 4;  // pclk cycles per SCL quarter period

  logic       pclk = 1'b0;
  logic       areset = 1'b1;
  logic       scl_drv = 1'b1;
  logic       msda = 1'b1;
  logic       scl_i, sda_i, sda_oe;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_wr_en, reg_rd_en, busy, nack_seen;

  logic [7:0] mem [256];

  always #5 pclk = ~pclk;

  assign scl_i     = scl_drv;
  assign sda_i     = msda & ~sda_oe;
  assign reg_rdata = mem[reg_addr];

  i2c_target_byte_engine dut (
    .pclk      (pclk),
    .areset    (areset),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .sda_oe    (sda_oe),
    .reg_addr  (reg_addr),
    .reg_wr_en (reg_wr_en),
    .reg_wdata (reg_wdata),
    .reg_rd_en (reg_rd_en),
    .reg_rdata (reg_rdata),
    .busy      (busy),
    .nack_seen (nack_seen)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction model
  typedef struct packed {logic [7:0] a; logic [7:0] d;} wr_t;
  wr_t        exp_wr[$];
  logic [7:0] exp_rd[$];
  logic [7:0] m_ptr = 8'h00;
  int         m_nack = 0;
  logic [7:0] log_a[$], log_d[$];
  int         wr_cnt = 0, rd_cnt = 0, nack_cnt = 0;
  bit         oe_seen = 0;

  function automatic logic model_ack(input logic [7:0] addr_byte);
    return (addr_byte[7:1] == 7'h68) ? 1'b0 : 1'b1;
  endfunction

  initial begin : cmp
    logic prev_oe;
    wr_t  e;
    logic [7:0] ea;
    prev_oe = 1'b0;
    forever begin
      @(negedge pclk);
      if (areset) begin
        if (sda_oe) oe_seen = 1;
        if (sda_oe !== prev_oe) check("oe_change_while_scl_high", scl_i, 0);
        if (reg_wr_en) begin
          wr_cnt++;
          log_a.push_back(reg_addr);
          log_d.push_back(reg_wdata);
          if (exp_wr.size() == 0) check("unexpected_wr", 1, 0);
          else begin
            e = exp_wr.pop_front();
            check("wr_addr", reg_addr, e.a);
            check("wr_data", reg_wdata, e.d);
          end
        end
        if (reg_rd_en) begin
          rd_cnt++;
          if (exp_rd.size() == 0) check("unexpected_rd", 1, 0);
          else begin
            ea = exp_rd.pop_front();
            check("rd_addr", reg_addr, ea);
          end
        end
        if (nack_seen) nack_cnt++;
      end
      prev_oe = sda_oe;
    end
  end

  task automatic wq(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic i2c_start();
    msda = 1'b1; wq(Q); scl_drv = 1'b1; wq(Q); msda = 1'b0; wq(Q); scl_drv = 1'b0; wq(Q);
  endtask

  task automatic i2c_stop();
    msda = 1'b0; wq(Q); scl_drv = 1'b1; wq(Q); msda = 1'b1; wq(2*Q);
  endtask

  task automatic bit_xfer(input logic b, output logic s);
    msda = b; wq(Q); scl_drv = 1'b1; wq(Q); s = sda_i; wq(Q); scl_drv = 1'b0; wq(Q);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], s);
    bit_xfer(1'b1, ack);
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic mack);
    logic s;
    for (int i = 7; i >= 0; i--) begin bit_xfer(1'b1, s); d[i] = s; end
    bit_xfer(mack, s);
  endtask

  initial begin : wdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic       ack, s;
    logic [7:0] d;
    logic [7:0] wdat[2];
    int         wr0, rd0;

    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
    mem[8'h20] = 8'h3C;
    mem[8'h21] = 8'hC3;

    #1 areset = 1'b0;
    wq(3);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_strobes", {reg_wr_en, reg_rd_en, nack_seen}, 0);
    check("rst_addr", reg_addr, 0);
    areset = 1'b1;
    wq(4);

    // Write D0, 10, A5, 5A
    log_a.delete(); log_d.delete();
    wdat[0] = 8'hA5; wdat[1] = 8'h5A;
    i2c_start();
    send_byte(8'hD0, ack); check("w1_addr_ack", ack, model_ack(8'hD0));
    check("w1_busy", busy, 1);
    send_byte(8'h10, ack); check("w1_reg_ack", ack, 0);
    m_ptr = 8'h10;
    for (int i = 0; i < 2; i++) begin
      exp_wr.push_back({m_ptr, wdat[i]});
      send_byte(wdat[i], ack); check("w1_data_ack", ack, 0);
      m_ptr = m_ptr + 8'd1;
    end
    i2c_stop();
    check("w1_busy_stop", busy, 0);
    check("w1_nwr", log_a.size(), 2);
    if (log_a.size() == 2) begin
      check("w1_lit_a0", log_a[0], 8'h10); check("w1_lit_d0", log_d[0], 8'hA5);
      check("w1_lit_a1", log_a[1], 8'h11); check("w1_lit_d1", log_d[1], 8'h5A);
    end

    // Mismatched address D2
    oe_seen = 0; wr0 = wr_cnt; rd0 = rd_cnt;
    i2c_start();
    send_byte(8'hD2, ack); check("mm_addr_nack", ack, model_ack(8'hD2));
    check("mm_busy", busy, 0);
    send_byte(8'h10, ack); check("mm_byte_nack", ack, 1);
    send_byte(8'h77, ack); check("mm_byte2_nack", ack, 1);
    i2c_stop();
    check("mm_oe_never", oe_seen, 0);
    check("mm_no_wr", wr_cnt - wr0, 0);
    check("mm_no_rd", rd_cnt - rd0, 0);

    // Write pointer 20, repeated START, read two bytes
    i2c_start();
    send_byte(8'hD0, ack); check("r_addrw_ack", ack, 0);
    send_byte(8'h20, ack); check("r_reg_ack", ack, 0);
    m_ptr = 8'h20;
    i2c_start();
    exp_rd.push_back(m_ptr);
    send_byte(8'hD1, ack); check("r_addrr_ack", ack, model_ack(8'hD1));
    check("r_busy", busy, 1);
    exp_rd.push_back(m_ptr + 8'd1);
    recv_byte(d, 1'b0);
    check("r_byte0", d, mem[m_ptr]); check("r_byte0_lit", d, 8'h3C);
    m_ptr = m_ptr + 8'd1;
    recv_byte(d, 1'b1);
    m_nack++;
    check("r_byte1", d, mem[m_ptr]); check("r_byte1_lit", d, 8'hC3);
    i2c_stop();
    check("r_nack_once", nack_cnt, 1);
    check("r_busy_stop", busy, 0);

    // Pointer wrap
    log_a.delete(); log_d.delete();
    wdat[0] = 8'h11; wdat[1] = 8'h22;
    i2c_start();
    send_byte(8'hD0, ack); check("wr_addr_ack", ack, 0);
    send_byte(8'hFF, ack); check("wr_reg_ack", ack, 0);
    m_ptr = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      exp_wr.push_back({m_ptr, wdat[i]});
      send_byte(wdat[i], ack); check("wrap_data_ack", ack, 0);
      m_ptr = m_ptr + 8'd1;
    end
    i2c_stop();
    if (log_a.size() == 2) begin
      check("wrap_lit_a0", log_a[0], 8'hFF); check("wrap_lit_a1", log_a[1], 8'h00);
    end else check("wrap_nwr", log_a.size(), 2);

    // STOP after 5 bits of a data byte
    wr0 = wr_cnt;
    i2c_start();
    send_byte(8'hD0, ack); check("p_addr_ack", ack, 0);
    send_byte(8'h40, ack); check("p_reg_ack", ack, 0);
    m_ptr = 8'h40;
    d = 8'hB6;
    for (int i = 7; i > 2; i--) bit_xfer(d[i], s);
    i2c_stop();
    check("p_no_wr", wr_cnt - wr0, 0);
    check("p_busy", busy, 0);
    check("p_oe", sda_oe, 0);

    // Reset while driving a 0 read bit
    mem[m_ptr] = 8'h3C;
    i2c_start();
    exp_rd.push_back(m_ptr);
    send_byte(8'hD1, ack); check("ar_addr_ack", ack, 0);
    msda = 1'b1; wq(Q); scl_drv = 1'b1; wq(Q);
    check("ar_drive_bit7", sda_oe, 1);
    #2 areset = 1'b0;
    #1;
    check("ar_oe_now", sda_oe, 0);
    check("ar_busy", busy, 0);
    check("ar_strobes", {reg_wr_en, reg_rd_en, nack_seen}, 0);
    check("ar_addr", reg_addr, 0);
    check("ar_wdata", reg_wdata, 0);
    wq(3);
    scl_drv = 1'b1; msda = 1'b1;
    wq(2);
    areset = 1'b1;
    m_ptr = 8'h00;
    wq(2*Q);

    // After reset the pointer reads back from 0
    i2c_start();
    exp_rd.push_back(m_ptr);
    send_byte(8'hD1, ack); check("pr_addr_ack", ack, 0);
    recv_byte(d, 1'b1);
    m_nack++;
    check("pr_byte", d, mem[m_ptr]);
    i2c_stop();

    check("end_wr_queue", exp_wr.size(), 0);
    check("end_rd_queue", exp_rd.size(), 0);
    check("end_nack_cnt", nack_cnt, m_nack);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
